// File: rtl/one_dimensional_node_pkg.sv
// Shared constants and port codes for the 1-D router node.
package one_dimensional_node_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEST_MSB = 31;
    localparam int unsigned DEST_LSB = 24;
    localparam int unsigned HOP_MSB  = 23;
    localparam int unsigned HOP_LSB  = 16;

    typedef enum logic [1:0] {
        PORT_NONE  = 2'b00,
        PORT_LEFT  = 2'b01,
        PORT_RIGHT = 2'b10,
        PORT_SELF  = 2'b11
    } port_t;

endpackage

// File: rtl/node_arbiter.sv
// Picks one of three buffered requests (bit0 left, bit1 right, bit2 self) per cycle.
// ROUND_ROBIN_ARB_EN selects rotating priority; otherwise fixed self > left > right.
module node_arbiter
    import one_dimensional_node_pkg::*;
(
    input  logic [2:0] req,
    output logic [1:0] grant
`ifdef ROUND_ROBIN_ARB_EN
    ,
    input  logic       clk,
    input  logic       reset_n
`endif
);

`ifdef ROUND_ROBIN_ARB_EN
    // head: 0 = left first, 1 = right first, 2 = self first
    logic [1:0] head;

    always_comb begin
        grant = PORT_NONE;
        case (head)
            2'd1: begin
                if (req[1])      grant = PORT_RIGHT;
                else if (req[2]) grant = PORT_SELF;
                else if (req[0]) grant = PORT_LEFT;
            end
            2'd2: begin
                if (req[2])      grant = PORT_SELF;
                else if (req[0]) grant = PORT_LEFT;
                else if (req[1]) grant = PORT_RIGHT;
            end
            default: begin
                if (req[0])      grant = PORT_LEFT;
                else if (req[1]) grant = PORT_RIGHT;
                else if (req[2]) grant = PORT_SELF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head <= 2'd0;
        end else begin
            case (grant)
                PORT_LEFT:  head <= 2'd1;
                PORT_RIGHT: head <= 2'd2;
                PORT_SELF:  head <= 2'd0;
                default:    head <= head;
            endcase
        end
    end
`else
    always_comb begin
        grant = PORT_NONE;
        if (req[2])      grant = PORT_SELF;
        else if (req[0]) grant = PORT_LEFT;
        else if (req[1]) grant = PORT_RIGHT;
    end
`endif

endmodule

// File: rtl/one_dimensional_node.sv
// Router node of a linear interconnect: one-word buffers per input, one grant per cycle,
// routing by destination field. Macro ROUND_ROBIN_ARB_EN enables rotating arbitration.
module one_dimensional_node #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NODE_ID = 0
) (
    input  logic              shiftInCLK,
    input  logic              resetN,
    input  logic [DATA_W-1:0] shiftInLeftData,
    input  logic              shiftInLeftCS,
    input  logic [DATA_W-1:0] shiftInRightData,
    input  logic              shiftInRightCS,
    input  logic [DATA_W-1:0] shiftInData,
    input  logic              shiftInCS,
    output logic [DATA_W-1:0] shiftOutLeftData,
    output logic              shiftOutLeftCS,
    output logic [DATA_W-1:0] shiftOutRightData,
    output logic              shiftOutRightCS,
    output logic [DATA_W-1:0] shiftOutData,
    output logic              shiftOutCS,
    output logic              shiftOutCLK,
    output logic [1:0]        dataSource,
    output logic [1:0]        outputSelect,
    output logic              controllerEn,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] instructionTo
);
    import one_dimensional_node_pkg::*;

    localparam logic [7:0] NODE_ADDR = 8'(NODE_ID);

    logic [DATA_W-1:0] left_buf, right_buf, self_buf;
    logic              left_full, right_full, self_full;
    logic [1:0]        grant;
    logic [2:0]        take;
    logic [DATA_W-1:0] word, fwd_word;
    port_t             route;

    assign shiftOutCLK = shiftInCLK;

    node_arbiter u_arb (
        .req     ({self_full, right_full, left_full}),
        .grant   (grant)
`ifdef ROUND_ROBIN_ARB_EN
        ,
        .clk     (shiftInCLK),
        .reset_n (resetN)
`endif
    );

    always_comb begin
        take = '0;
        word = '0;
        case (grant)
            PORT_LEFT:  begin take[0] = 1'b1; word = left_buf;  end
            PORT_RIGHT: begin take[1] = 1'b1; word = right_buf; end
            PORT_SELF:  begin take[2] = 1'b1; word = self_buf;  end
            default:    ;
        endcase
        if (word[DEST_MSB:DEST_LSB] == NODE_ADDR)     route = PORT_SELF;
        else if (word[DEST_MSB:DEST_LSB] < NODE_ADDR) route = PORT_LEFT;
        else                                          route = PORT_RIGHT;
        fwd_word = word;
        if (route != PORT_SELF) fwd_word[HOP_MSB:HOP_LSB] = word[HOP_MSB:HOP_LSB] + 8'd1;
    end

    always_ff @(posedge shiftInCLK) begin
        if (!resetN) begin
            left_buf          <= '0;
            right_buf         <= '0;
            self_buf          <= '0;
            left_full         <= 1'b0;
            right_full        <= 1'b0;
            self_full         <= 1'b0;
            shiftOutLeftData  <= '0;
            shiftOutLeftCS    <= 1'b0;
            shiftOutRightData <= '0;
            shiftOutRightCS   <= 1'b0;
            shiftOutData      <= '0;
            shiftOutCS        <= 1'b0;
            dataSource        <= PORT_NONE;
            outputSelect      <= PORT_NONE;
            controllerEn      <= 1'b0;
            instruction       <= '0;
            instructionTo     <= '0;
        end else begin
            // A buffer granted this edge is free again, so a same-edge strobe refills it.
            if (shiftInLeftCS && (!left_full || take[0])) begin
                left_buf  <= shiftInLeftData;
                left_full <= 1'b1;
            end else if (take[0]) begin
                left_full <= 1'b0;
            end
            if (shiftInRightCS && (!right_full || take[1])) begin
                right_buf  <= shiftInRightData;
                right_full <= 1'b1;
            end else if (take[1]) begin
                right_full <= 1'b0;
            end
            if (shiftInCS && (!self_full || take[2])) begin
                self_buf  <= shiftInData;
                self_full <= 1'b1;
            end else if (take[2]) begin
                self_full <= 1'b0;
            end

            controllerEn    <= (grant != PORT_NONE);
            dataSource      <= grant;
            outputSelect    <= PORT_NONE;
            shiftOutLeftCS  <= 1'b0;
            shiftOutRightCS <= 1'b0;
            shiftOutCS      <= 1'b0;
            if (grant != PORT_NONE) begin
                instruction   <= word;
                instructionTo <= fwd_word;
                outputSelect  <= route;
                case (route)
                    PORT_LEFT: begin
                        shiftOutLeftData <= fwd_word;
                        shiftOutLeftCS   <= 1'b1;
                    end
                    PORT_RIGHT: begin
                        shiftOutRightData <= fwd_word;
                        shiftOutRightCS   <= 1'b1;
                    end
                    default: begin
                        shiftOutData <= fwd_word;
                        shiftOutCS   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_one_dimensional_node.sv
// Scoreboard bench for one_dimensional_node (NODE_ID=5); model follows ROUND_ROBIN_ARB_EN if defined.
module tb_one_dimensional_node;

    localparam int unsigned NODE = 5;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] l_data = '0, r_data = '0, s_data = '0;
    logic        l_cs = 1'b0, r_cs = 1'b0, s_cs = 1'b0;
    logic [31:0] out_l_data, out_r_data, out_s_data, instr, instr_to;
    logic        out_l_cs, out_r_cs, out_s_cs, out_clk, ctrl_en;
    logic [1:0]  src, osel;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit        en;
        bit [1:0]  src, osel;
        bit [31:0] instr, instr_to, ld, rd, sd;
        bit        lcs, rcs, scs;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit        m_full[3];
    bit [31:0] m_data[3];
    int        rr_head;

    one_dimensional_node #(.DATA_W(32), .NODE_ID(NODE)) dut (
        .shiftInCLK        (clk),
        .resetN            (resetN),
        .shiftInLeftData   (l_data),
        .shiftInLeftCS     (l_cs),
        .shiftInRightData  (r_data),
        .shiftInRightCS    (r_cs),
        .shiftInData       (s_data),
        .shiftInCS         (s_cs),
        .shiftOutLeftData  (out_l_data),
        .shiftOutLeftCS    (out_l_cs),
        .shiftOutRightData (out_r_data),
        .shiftOutRightCS   (out_r_cs),
        .shiftOutData      (out_s_data),
        .shiftOutCS        (out_s_cs),
        .shiftOutCLK       (out_clk),
        .dataSource        (src),
        .outputSelect      (osel),
        .controllerEn      (ctrl_en),
        .instruction       (instr),
        .instructionTo     (instr_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus; the model computes what the node should show after that edge.
    task automatic apply_edge(input bit rst, input bit [2:0] cs,
                              input bit [31:0] l, input bit [31:0] r, input bit [31:0] s);
        bit [31:0] win[3];
        int order[3];
        int g;
        bit [31:0] w, to;
        int dest, hop;
        @(negedge clk);
        resetN = !rst;
        l_cs = cs[0]; r_cs = cs[1]; s_cs = cs[2];
        l_data = l; r_data = r; s_data = s;
        win = '{l, r, s};
        if (rst) begin
            cur = '{default: 0};
            m_full = '{0, 0, 0};
            m_data = '{0, 0, 0};
            rr_head = 0;
        end else begin
`ifdef ROUND_ROBIN_ARB_EN
            order = '{rr_head, (rr_head + 1) % 3, (rr_head + 2) % 3};
`else
            order = '{2, 0, 1};
`endif
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && m_full[order[k]]) g = order[k];
            cur.en = 0; cur.src = 0; cur.osel = 0;
            cur.lcs = 0; cur.rcs = 0; cur.scs = 0;
            if (g >= 0) begin
                w = m_data[g];
                m_full[g] = 0;
                rr_head = (g + 1) % 3;
                dest = int'(w / 32'h0100_0000);
                hop  = int'((w / 32'h0001_0000) % 256);
                if (dest == NODE) to = w;
                else to = (w & 32'hFF00_FFFF) + 32'((hop + 1) % 256) * 32'h0001_0000;
                cur.en = 1;
                cur.src = 2'(g + 1);
                cur.instr = w;
                cur.instr_to = to;
                if (dest == NODE)     begin cur.osel = 2'b11; cur.sd = to; cur.scs = 1; end
                else if (dest < NODE) begin cur.osel = 2'b01; cur.ld = to; cur.lcs = 1; end
                else                  begin cur.osel = 2'b10; cur.rd = to; cur.rcs = 1; end
            end
            for (int k = 0; k < 3; k++)
                if (cs[k] && !m_full[k]) begin
                    m_full[k] = 1;
                    m_data[k] = win[k];
                end
        end
        q.push_back(cur);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_edge(0, 3'b000, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("controllerEn", 32'(ctrl_en), 32'(e.en));
                chk("dataSource", 32'(src), 32'(e.src));
                chk("outputSelect", 32'(osel), 32'(e.osel));
                chk("instruction", instr, e.instr);
                chk("instructionTo", instr_to, e.instr_to);
                chk("leftCS", 32'(out_l_cs), 32'(e.lcs));
                chk("rightCS", 32'(out_r_cs), 32'(e.rcs));
                chk("selfCS", 32'(out_s_cs), 32'(e.scs));
                chk("leftData", out_l_data, e.ld);
                chk("rightData", out_r_data, e.rd);
                chk("selfData", out_s_data, e.sd);
                chk("clkPass", 32'(out_clk), 32'(clk));
            end
        end
    end

    initial begin : stimulus
        bit [2:0]  cs;
        bit [31:0] w[3];
        bit [7:0]  d;
        apply_edge(1, 3'b000, 0, 0, 0);
        apply_edge(1, 3'b000, 0, 0, 0);
        idle(1);
        // single right word
        apply_edge(0, 3'b010, 0, 42, 0);
        idle(3);
        // simultaneous three-port arrival
        apply_edge(0, 3'b111, 800, 500, 4);
        idle(4);
        // routing left, self and right, including hop wrap
        apply_edge(0, 3'b010, 0, 32'h0300_0001, 0);
        apply_edge(0, 3'b100, 0, 0, 32'h0500_00AA);
        apply_edge(0, 3'b001, 32'h09FF_1234, 0, 0);
        idle(3);
        // second right word while buffer still full is dropped
        apply_edge(0, 3'b111, 800, 500, 4);
        apply_edge(0, 3'b010, 0, 2, 0);
        idle(4);
        // mid-operation reset drops pending words
        apply_edge(0, 3'b101, 73, 0, 89);
        apply_edge(1, 3'b000, 0, 0, 0);
        idle(3);
        // saturated inputs
        for (int i = 0; i < 9; i++)
            apply_edge(0, 3'b111, 32'h0000_1000 + 32'(i), 32'h0700_2000 + 32'(i), 32'h0500_3000 + 32'(i));
        idle(3);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cs = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                d = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 10));
                w[k] = {d, 8'($urandom), 16'($urandom)};
            end
            apply_edge($urandom_range(0, 63) == 0, cs, w[0], w[1], w[2]);
        end
        idle(4);
        @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
